// File: rtl/ct_spsram_512x22_ctrl.sv
// ct_spsram_512x22_ctrl
//   Requester-side controller for a 512x22 single-port SRAM macro. It accepts a
//   valid/ready read/write request stream and drives the macro pins CEN/GWEN/WEN/A/D
//   combinationally from the FSM state and the accepted request. Read data is returned
//   two cycles after accept. After reset, or on init_req, every entry is written with
//   INIT_VAL.
//
// Ports
//   forever_cpuclk  clock; the SRAM CLK is driven from the same net
//   cpurst_b        asynchronous active-low reset
//   init_req        pulse that starts a full-array init (taken only when idle)
//   init_busy       high while an init is pending or running
//   init_done       one-cycle pulse in the first idle cycle after the last init write
//   req_vld/req_rdy request handshake; the request is accepted when both are high
//   req_wr          1 = write, 0 = read
//   req_addr        request address
//   req_wdata       write data
//   req_wmask       per-bit write enable, active high
//   rd_vld          read-data valid pulse, no back-pressure
//   rd_data         read data, held until the next rd_vld
//   sram_a/cen/gwen/wen/d  pins to the macro; cen, gwen and wen are active low
//   sram_q          macro output, valid the cycle after a read access

module ct_spsram_512x22_ctrl #(
    parameter int unsigned           ADDR_WIDTH = 9,
    parameter int unsigned           DATA_WIDTH = 22,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_req,
    output logic                  init_busy,
    output logic                  init_done,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rd_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    // One spare bit so the counter can hold the depth; termination never depends on wrap.
    localparam int unsigned       CntW     = ADDR_WIDTH + 1;
    localparam logic [CntW-1:0]   LastAddr = {1'b0, {ADDR_WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        StInitPend,
        StInit,
        StIdle
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  init_done_q, init_done_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  acc_rd;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = 1'b0;
        req_rdy     = 1'b0;
        acc_rd      = 1'b0;
        sram_cen    = 1'b1;
        sram_gwen   = 1'b1;
        sram_wen    = '1;
        sram_a      = '0;
        sram_d      = '0;

        unique case (state_q)
            // One quiet cycle before the first init write.
            StInitPend: begin
                state_d = StInit;
            end
            StInit: begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
                sram_wen  = '0;
                sram_a    = cnt_q[ADDR_WIDTH-1:0];
                sram_d    = INIT_VAL;
                if (cnt_q == LastAddr) begin
                    state_d     = StIdle;
                    cnt_d       = '0;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StIdle: begin
                if (init_req) begin
                    // init_req wins over a pending request: nothing is accepted this cycle.
                    cnt_d   = '0;
                    state_d = StInitPend;
                end else begin
                    req_rdy = 1'b1;
                    if (req_vld) begin
                        sram_cen = 1'b0;
                        sram_a   = req_addr;
                        if (req_wr) begin
                            sram_gwen = 1'b0;
                            sram_wen  = ~req_wmask;
                            sram_d    = req_wdata;
                        end else begin
                            acc_rd = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = StInitPend;
                cnt_d   = '0;
            end
        endcase

        // Read pipeline: accept in N, macro Q valid in N+1 and captured, rd_vld in N+2.
        // It runs independently of the FSM so reads in flight survive an init_req.
        rd_pend_d = acc_rd;
        rd_vld_d  = rd_pend_q;
        rd_data_d = rd_pend_q ? sram_q : rd_data_q;
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q     <= StInitPend;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            rd_pend_q   <= rd_pend_d;
            rd_vld_q    <= rd_vld_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign init_busy = (state_q != StIdle);
    assign init_done = init_done_q;
    assign rd_vld    = rd_vld_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_ct_spsram_512x22_ctrl.sv
// Testbench for ct_spsram_512x22_ctrl: drives requests, models the SRAM macro behind
// the pins, predicts read data from a plain array model and checks rd_data/rd_vld
// timing through a scoreboard queue popped by an independent monitor.

module tb_ct_spsram_512x22_ctrl;

    localparam int unsigned AW    = 9;
    localparam int unsigned DW    = 22;
    localparam int unsigned DEPTH = 512;
    localparam logic [DW-1:0] INIT_VAL = '0;
    localparam logic [DW-1:0] ONES     = '1;

    logic          forever_cpuclk;
    logic          cpurst_b;
    logic          init_req;
    logic          init_busy;
    logic          init_done;
    logic          req_vld;
    logic          req_rdy;
    logic          req_wr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [DW-1:0] req_wmask;
    logic          rd_vld;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    ct_spsram_512x22_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_VAL   (INIT_VAL)
    ) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .init_req       (init_req),
        .init_busy      (init_busy),
        .init_done      (init_done),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_wr         (req_wr),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_wmask      (req_wmask),
        .rd_vld         (rd_vld),
        .rd_data        (rd_data),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    initial forever_cpuclk = 1'b0;
    always #5 forever_cpuclk = ~forever_cpuclk;

    int cyc = 0;
    always @(posedge forever_cpuclk) cyc <= cyc + 1;

    // SRAM macro model, random power-up contents.
    logic [DW-1:0] sram_mem [DEPTH];
    initial begin
        for (int i = 0; i < int'(DEPTH); i++) sram_mem[i] = DW'($urandom);
        sram_q = '0;
    end
    always @(posedge forever_cpuclk) begin
        if (!sram_cen) begin
            if (!sram_gwen) sram_mem[sram_a] = (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= sram_mem[sram_a];
        end
    end

    // Reference model and scoreboard.
    logic [DW-1:0] ref_mem [DEPTH];
    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    always @(negedge forever_cpuclk) begin
        exp_t e;
        if (cpurst_b && rd_vld) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rd_vld_unexpected: got rd_vld=1 data 0x%0h expected no read (cycle %0d)",
                         rd_data, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", 32'(rd_data), 32'(e.data));
                chk("rd_vld_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    task automatic model_init();
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = INIT_VAL;
    endtask

    task automatic chk_idle_pins(input string tag);
        chk({tag, "_cen"},  32'(sram_cen),  1);
        chk({tag, "_gwen"}, 32'(sram_gwen), 1);
        chk({tag, "_wen"},  32'(sram_wen),  32'(ONES));
        chk({tag, "_a"},    32'(sram_a),    0);
        chk({tag, "_d"},    32'(sram_d),    0);
    endtask

    // Called at the negedge of the quiet cycle that precedes the init writes.
    task automatic run_init(input int n_writes, input bit full);
        #1;
        chk("initpend_cen", 32'(sram_cen), 1);
        chk("initpend_busy", 32'(init_busy), 1);
        chk("initpend_rdy", 32'(req_rdy), 0);
        for (int i = 0; i < n_writes; i++) begin
            @(negedge forever_cpuclk);
            chk("init_cen",  32'(sram_cen),  0);
            chk("init_gwen", 32'(sram_gwen), 0);
            chk("init_wen",  32'(sram_wen),  0);
            chk("init_a",    32'(sram_a),    i);
            chk("init_d",    32'(sram_d),    32'(INIT_VAL));
            chk("init_busy", 32'(init_busy), 1);
            chk("init_rdy",  32'(req_rdy),   0);
            chk("init_done_early", 32'(init_done), 0);
        end
        if (full) begin
            @(negedge forever_cpuclk);
            chk("init_done_pulse", 32'(init_done), 1);
            chk("init_done_rdy",   32'(req_rdy),   1);
            chk("init_done_busy",  32'(init_busy), 0);
            chk("init_done_cen",   32'(sram_cen),  1);
            @(negedge forever_cpuclk);
            chk("init_done_clear", 32'(init_done), 0);
        end
    endtask

    // Drive one request at the current negedge; returns at the next negedge.
    task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [DW-1:0] wm);
        logic [DW-1:0] exp_wen;
        req_vld = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd; req_wmask = wm;
        #1;
        chk("req_rdy", 32'(req_rdy), 1);
        if (req_rdy) begin
            exp_wen = wr ? ~wm : ONES;
            chk("acc_cen",  32'(sram_cen),  0);
            chk("acc_gwen", 32'(sram_gwen), 32'(!wr));
            chk("acc_a",    32'(sram_a),    32'(addr));
            chk("acc_wen",  32'(sram_wen),  32'(exp_wen));
            if (wr) begin
                chk("acc_d", 32'(sram_d), 32'(wd));
                ref_mem[addr] = (ref_mem[addr] & ~wm) | (wd & wm);
            end else begin
                exp_q.push_back('{data: ref_mem[addr], due: cyc + 2});
            end
        end
        @(negedge forever_cpuclk);
    endtask

    task automatic idle_req();
        req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge forever_cpuclk);
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic start_init();
        init_req = 1'b1;
        #1;
        chk("initreq_rdy", 32'(req_rdy), 0);
        chk("initreq_cen", 32'(sram_cen), 1);
        @(negedge forever_cpuclk);
        init_req = 1'b0;
        idle_req();
        model_init();
    endtask

    initial begin
        cpurst_b = 1'b0;
        init_req = 1'b0;
        idle_req();
        model_init();

        repeat (2) @(negedge forever_cpuclk);
        chk("rst_rdy",  32'(req_rdy),   0);
        chk("rst_busy", 32'(init_busy), 1);
        chk("rst_done", 32'(init_done), 0);
        chk("rst_rdvld", 32'(rd_vld),   0);
        chk("rst_rddata", 32'(rd_data), 0);
        chk_idle_pins("rst");

        cpurst_b = 1'b1;
        run_init(DEPTH, 1'b1);

        // Full-mask write then read back.
        issue(1'b1, 9'h1A5, 22'h2AAAAA, ONES);
        issue(1'b0, 9'h1A5, '0, '0);
        idle_req();
        drain();

        // Partial mask, and a fully masked write that must change nothing.
        issue(1'b1, 9'h0A0, 22'h000000, ONES);
        issue(1'b1, 9'h0A0, 22'h3FFFFF, 22'h0007FF);
        issue(1'b0, 9'h0A0, '0, '0);
        issue(1'b1, 9'h0A0, 22'h12345, 22'h0);
        issue(1'b0, 9'h0A0, '0, '0);
        issue(1'b0, 9'h1FF, '0, '0);
        idle_req();
        drain();

        // Back-to-back reads, then init_req while they are still in flight.
        for (int i = 0; i < 4; i++) issue(1'b1, AW'(i), DW'(32'h1000 + i * 32'h111), ONES);
        for (int i = 0; i < 4; i++) issue(1'b0, AW'(i), '0, '0);
        idle_req();
        start_init();
        run_init(DEPTH, 1'b1);
        chk("inflight_pending", exp_q.size(), 0);

        // init_req together with req_vld: the request is not taken.
        issue(1'b1, 9'h005, 22'h155555, ONES);
        req_vld = 1'b1; req_wr = 1'b1; req_addr = 9'h006; req_wdata = 22'h3F0F0F; req_wmask = ONES;
        start_init();
        run_init(DEPTH, 1'b1);
        issue(1'b0, 9'h005, '0, '0);
        issue(1'b0, 9'h006, '0, '0);
        idle_req();
        drain();

        // Reset in the middle of an init.
        start_init();
        run_init(300, 1'b0);
        @(negedge forever_cpuclk);
        chk("midinit_a", 32'(sram_a), 300);
        cpurst_b = 1'b0;
        #1;
        chk_idle_pins("midrst");
        chk("midrst_busy", 32'(init_busy), 1);
        chk("midrst_rdy", 32'(req_rdy), 0);
        exp_q.delete();
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        model_init();
        run_init(DEPTH, 1'b1);

        // Randomized traffic over a small address window to force reuse.
        for (int n = 0; n < 400; n++) begin
            int unsigned op;
            logic [DW-1:0] m;
            op = $urandom_range(0, 3);
            m  = ($urandom_range(0, 1) == 0) ? ONES : DW'($urandom);
            if (op == 0) begin
                idle_req();
                @(negedge forever_cpuclk);
            end else if (op == 1) begin
                issue(1'b1, AW'($urandom_range(0, 31)), DW'($urandom), m);
            end else begin
                issue(1'b0, AW'($urandom_range(0, 31)), '0, '0);
            end
        end
        idle_req();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
